// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port data memory between the pipeline MEM stage
// (port P) and the DMA/debug loader (port D).
// Ports:
//   ma_clk, ma_rst              clock, async active-low reset
//   p_req/p_we/p_addr/p_wdata   P request (held until p_gnt)
//   p_gnt                       P accepted this cycle (combinational)
//   p_rvalid                    P read data valid (one-cycle pulse)
//   d_*                         same for port D; d_lock requests a burst lock
//   rdata                       shared load data (pass-through of mem_rdata)
//   mem_ce/wr_en/rd_en/addr/wdata  registered memory command
//   mem_rdata                   memory load data, valid one cycle after rd_en
`ifndef AWIDTH_MEM
`define AWIDTH_MEM 10
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module mem_arbiter #(
    parameter int unsigned AWIDTH       = `AWIDTH_MEM,
    parameter int unsigned DWIDTH       = `DWIDTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              ma_clk,
    input  logic              ma_rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [AWIDTH-1:0] p_addr,
    input  logic [DWIDTH-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DWIDTH-1:0] rdata,
    output logic              mem_ce,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCK_D = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              w_lock_hold;
    logic              w_p_gnt;
    logic              w_d_gnt;
    logic              w_gnt_any;
    logic              w_sel_we;
    logic [AWIDTH-1:0] w_sel_addr;
    logic [DWIDTH-1:0] w_sel_wdata;

    logic              r_mem_ce;
    logic              r_mem_wr_en;
    logic              r_mem_rd_en;
    logic [AWIDTH-1:0] r_mem_addr;
    logic [DWIDTH-1:0] r_mem_wdata;
    logic              r_pend;
    logic              r_owner;
    logic              r_p_rvalid;
    logic              r_d_rvalid;

    // State register.
    always_ff @(posedge ma_clk or negedge ma_rst) begin
        if (!ma_rst) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration and next state. A held lock is re-evaluated against the
    // current d_lock, so the cycle that drops it already arbitrates normally.
    always_comb begin
        w_state_nxt = r_state;
        w_p_gnt     = 1'b0;
        w_d_gnt     = 1'b0;
        w_lock_hold = (r_state == ST_LOCK_D) && d_lock;
        if (ma_rst) begin
            if (w_lock_hold) begin
                w_d_gnt = d_req;
            end else if (d_req && (r_starve_cnt == STARVE_MAX)) begin
                w_d_gnt = 1'b1;
            end else if (p_req) begin
                w_p_gnt = 1'b1;
            end else if (d_req) begin
                w_d_gnt = 1'b1;
            end
        end
        if (w_d_gnt && d_lock) begin
            w_state_nxt = ST_LOCK_D;
        end else if (!w_lock_hold) begin
            w_state_nxt = ST_ARB;
        end
    end

    // D starvation counter, saturating at the limit.
    always_ff @(posedge ma_clk or negedge ma_rst) begin
        if (!ma_rst) begin
            r_starve_cnt <= '0;
        end else if (!d_req || w_d_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    assign w_gnt_any   = w_p_gnt | w_d_gnt;
    assign w_sel_we    = w_d_gnt ? d_we    : p_we;
    assign w_sel_addr  = w_d_gnt ? d_addr  : p_addr;
    assign w_sel_wdata = w_d_gnt ? d_wdata : p_wdata;

    // Command stage and read-return tracking; address/data hold when idle.
    always_ff @(posedge ma_clk or negedge ma_rst) begin
        if (!ma_rst) begin
            r_mem_ce    <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pend      <= 1'b0;
            r_owner     <= 1'b0;
            r_p_rvalid  <= 1'b0;
            r_d_rvalid  <= 1'b0;
        end else begin
            r_mem_ce    <= w_gnt_any;
            r_mem_wr_en <= w_gnt_any & w_sel_we;
            r_mem_rd_en <= w_gnt_any & ~w_sel_we;
            if (w_gnt_any) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_owner     <= w_d_gnt;
            end
            r_pend      <= w_gnt_any & ~w_sel_we;
            r_p_rvalid  <= r_pend & ~r_owner;
            r_d_rvalid  <= r_pend & r_owner;
        end
    end

    assign p_gnt     = w_p_gnt;
    assign d_gnt     = w_d_gnt;
    assign p_rvalid  = r_p_rvalid;
    assign d_rvalid  = r_d_rvalid;
    assign rdata     = mem_rdata;
    assign mem_ce    = r_mem_ce;
    assign mem_wr_en = r_mem_wr_en;
    assign mem_rd_en = r_mem_rd_en;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a synchronous single-port memory model.
module tb_mem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          ma_clk;
    logic          ma_rst;
    logic          p_req, p_we, p_gnt, p_rvalid;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic          d_req, d_we, d_lock, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] rdata;
    logic          mem_ce, mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram    [256];
    logic [DW-1:0] shadow [256];

    int n_tests = 0;
    int n_fail  = 0;

    // Expected read return for the grant accepted one edge earlier.
    logic          s1_rd  = 1'b0;
    logic          s1_own = 1'b0;
    logic [DW-1:0] s1_data = '0;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_LIMIT(4)) dut (
        .ma_clk(ma_clk), .ma_rst(ma_rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rdata(rdata),
        .mem_ce(mem_ce), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial ma_clk = 1'b0;
    always #5 ma_clk = ~ma_clk;

    // Synchronous memory: samples the command at the edge, read data next cycle.
    always @(posedge ma_clk) begin
        if (mem_ce && mem_wr_en) ram[mem_addr] <= mem_wdata;
        if (mem_ce && mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive both ports, check grants, then check the
    // registered command and the read return of the previous grant.
    task automatic step(input logic pr, input logic pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                        input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                        input logic dl, input logic ep, input logic ed);
        logic          g_any;
        logic          g_we;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_wd;
        logic [DW-1:0] g_data;
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_lock = dl;
        #1;
        chk("p_gnt", 64'(p_gnt), 64'(ep));
        chk("d_gnt", 64'(d_gnt), 64'(ed));
        g_any  = ep | ed;
        g_we   = ed ? dw : pw;
        g_addr = ed ? da : pa;
        g_wd   = ed ? dd : pd;
        g_data = '0;
        if (g_any && g_we)  shadow[g_addr] = g_wd;
        if (g_any && !g_we) g_data = shadow[g_addr];
        @(posedge ma_clk); #1;
        chk("mem_ce", 64'(mem_ce), 64'(g_any));
        chk("mem_wr_en", 64'(mem_wr_en), 64'(g_any & g_we));
        chk("mem_rd_en", 64'(mem_rd_en), 64'(g_any & ~g_we));
        if (g_any) chk("mem_addr", 64'(mem_addr), 64'(g_addr));
        if (g_any && g_we) chk("mem_wdata", 64'(mem_wdata), 64'(g_wd));
        chk("p_rvalid", 64'(p_rvalid), 64'(s1_rd & ~s1_own));
        chk("d_rvalid", 64'(d_rvalid), 64'(s1_rd & s1_own));
        if (s1_rd) chk("rdata", 64'(rdata), 64'(s1_data));
        s1_rd   = g_any & ~g_we;
        s1_own  = ed;
        s1_data = g_data;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        ma_rst = 1'b0;
        p_req = 1'b1; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;
        repeat (2) @(posedge ma_clk);
        #1;
        // Reset state; grants suppressed while reset is low.
        chk("rst_p_gnt", 64'(p_gnt), 64'd0);
        chk("rst_d_gnt", 64'(d_gnt), 64'd0);
        chk("rst_mem_ce", 64'(mem_ce), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_rvalid", 64'({p_rvalid, d_rvalid}), 64'd0);
        chk("rst_starve", 64'(dut.r_starve_cnt), 64'd0);
        p_req = 1'b0; d_req = 1'b0;
        ma_rst = 1'b1;

        // P writes 0..9 then reads them back, one access per cycle.
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, AW'(i), DW'(i), 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle();
        idle();

        // Both ports requesting: P,P,P,P,D repeating with the starvation guard.
        begin
            logic [3:0] exp_cnt [10];
            logic       exp_d   [10];
            exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
            exp_d   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            for (int i = 0; i < 10; i++) begin
                step(1'b1, 1'b1, AW'(20 + i), DW'(32'h100 + i), 1'b1, 1'b0, AW'(2), '0, 1'b0,
                     ~exp_d[i], exp_d[i]);
                chk("starve_cnt", 64'(dut.r_starve_cnt), 64'(exp_cnt[i]));
            end
        end
        idle();
        idle();

        // D burst lock: starvation wins the first grant, lock holds two more.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, AW'(30), DW'(32'h30), 1'b1, 1'b1, AW'(5), DW'(32'h55), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, AW'(30), DW'(32'h30), 1'b1, 1'b1, AW'(5), DW'(32'h55), 1'b1, 1'b0, 1'b1);
        // Lock dropped: P wins the same cycle even though D still requests.
        step(1'b1, 1'b1, AW'(30), DW'(32'h31), 1'b1, 1'b1, AW'(5), DW'(32'h56), 1'b0, 1'b1, 1'b0);
        chk("lock_starve", 64'(dut.r_starve_cnt), 64'd1);
        idle();

        // P write then D read of the same address on the next cycle.
        step(1'b1, 1'b1, AW'(3), DW'(32'hAB), 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(3), '0, 1'b0, 1'b0, 1'b1);
        idle();
        idle();

        // Reset right after a read grant: command clears at once, no rvalid.
        step(1'b1, 1'b0, AW'(7), '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        p_req = 1'b1; p_we = 1'b0; p_addr = AW'(7);
        ma_rst = 1'b0;
        #1;
        chk("arst_mem_ce", 64'(mem_ce), 64'd0);
        chk("arst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        chk("arst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        chk("arst_mem_addr", 64'(mem_addr), 64'd0);
        chk("arst_p_gnt", 64'(p_gnt), 64'd0);
        @(posedge ma_clk); #1;
        chk("arst_p_rvalid", 64'(p_rvalid), 64'd0);
        chk("arst_d_rvalid", 64'(d_rvalid), 64'd0);
        @(posedge ma_clk); #1;
        chk("arst_p_rvalid2", 64'(p_rvalid), 64'd0);
        p_req = 1'b0;
        ma_rst = 1'b1;
        s1_rd = 1'b0;

        // Idle for five cycles: no commands, no returns.
        for (int i = 0; i < 5; i++) idle();

        // Read back the address written by the locked D burst.
        step(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
